// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding an 8N1 serializer (LSB first) on uart_tx.
// Status outputs (ready, level, busy, sticky overflow) feed the IO register reads.
//
// Write handshake: a byte is taken on any clock edge where i_wr_valid && o_wr_ready.
// o_wr_ready is registered; it goes low after the edge that fills the FIFO. A pop on
// that same edge does not reopen it until the next cycle. i_wr_valid while o_wr_ready
// is low drops the byte and sets o_overflow. There is no back-pressure stall.
module uart_tx_fifo #(
   parameter int CLK_FREQ   = 100000000,
   parameter int BAUD_RATE  = 115200,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               i_wr_valid,
   input  logic [7:0]                         i_wr_data,
   output logic                               o_wr_ready,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]    o_fifo_count,
   output logic                               o_busy,
   output logic                               o_overflow,
   input  logic                               i_clr_overflow,
   output logic                               uart_tx
);

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
   localparam int PTR_W        = $clog2(FIFO_DEPTH);
   localparam int CNT_W        = $clog2(FIFO_DEPTH + 1);
   localparam int TMR_W        = $clog2(CLKS_PER_BIT);

   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   // FIFO storage and bookkeeping
   logic [7:0]       mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_n;
   logic             push;
   logic             pop;

   // Serializer state
   state_t           state;
   state_t           state_n;
   logic [TMR_W-1:0] bit_tmr;
   logic [TMR_W-1:0] bit_tmr_n;
   logic [2:0]       bit_idx;
   logic [2:0]       bit_idx_n;
   logic [7:0]       shift;
   logic [7:0]       shift_n;
   logic             tx_n;

   assign push         = i_wr_valid && o_wr_ready;
   assign o_fifo_count = count;

   // Level update: simultaneous push and pop leave the count unchanged
   always_comb begin
      count_n = count;
      case ({push, pop})
         2'b10:   count_n = count + CNT_W'(1);
         2'b01:   count_n = count - CNT_W'(1);
         default: count_n = count;
      endcase
   end

   // Byte storage; contents are don't-care until written, so no reset
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= i_wr_data;
      end
   end

   // Pointers, level, registered ready and sticky overflow (set beats clear)
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         o_wr_ready <= 1'b1;
         o_overflow <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         count      <= count_n;
         o_wr_ready <= (count_n != CNT_FULL);
         if (i_wr_valid && !o_wr_ready) begin
            o_overflow <= 1'b1;
         end else if (i_clr_overflow) begin
            o_overflow <= 1'b0;
         end
      end
   end

   // Frame sequencing: start bit, 8 data bits LSB first, stop bit, back-to-back pops
   always_comb begin
      state_n   = state;
      bit_tmr_n = bit_tmr;
      bit_idx_n = bit_idx;
      shift_n   = shift;
      pop       = 1'b0;
      case (state)
         IDLE: begin
            if (count != '0) begin
               pop       = 1'b1;
               shift_n   = mem[rd_ptr];
               bit_tmr_n = '0;
               state_n   = START;
            end
         end
         START: begin
            if (bit_tmr == TMR_LAST) begin
               bit_tmr_n = '0;
               bit_idx_n = '0;
               state_n   = DATA;
            end else begin
               bit_tmr_n = bit_tmr + TMR_W'(1);
            end
         end
         DATA: begin
            if (bit_tmr == TMR_LAST) begin
               bit_tmr_n = '0;
               shift_n   = {1'b0, shift[7:1]};
               if (bit_idx == 3'd7) begin
                  state_n = STOP;
               end else begin
                  bit_idx_n = bit_idx + 3'd1;
               end
            end else begin
               bit_tmr_n = bit_tmr + TMR_W'(1);
            end
         end
         STOP: begin
            if (bit_tmr == TMR_LAST) begin
               bit_tmr_n = '0;
               if (count != '0) begin
                  pop     = 1'b1;
                  shift_n = mem[rd_ptr];
                  state_n = START;
               end else begin
                  state_n = IDLE;
               end
            end else begin
               bit_tmr_n = bit_tmr + TMR_W'(1);
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   // Line level for the upcoming cycle, registered so uart_tx never glitches
   always_comb begin
      tx_n = 1'b1;
      case (state_n)
         START:   tx_n = 1'b0;
         DATA:    tx_n = shift_n[0];
         default: tx_n = 1'b1;
      endcase
   end

   // Serializer registers; busy is computed from next values so it tracks state/count
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         bit_tmr <= '0;
         bit_idx <= '0;
         shift   <= '0;
         uart_tx <= 1'b1;
         o_busy  <= 1'b0;
      end else begin
         state   <= state_n;
         bit_tmr <= bit_tmr_n;
         bit_idx <= bit_idx_n;
         shift   <= shift_n;
         uart_tx <= tx_n;
         o_busy  <= (state_n != IDLE) || (count_n != '0);
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed checks of uart_tx_fifo at 10 clocks per bit, 4-entry FIFO.
// Inputs are driven and outputs sampled on the falling edge; the DUT acts on the rising edge.
module tb_uart_tx_fifo;

   logic       clk;
   logic       reset;
   logic       wr_valid;
   logic [7:0] wr_data;
   logic       wr_ready;
   logic [2:0] fifo_count;
   logic       busy;
   logic       overflow;
   logic       clr_overflow;
   logic       uart_tx;

   int total;
   int bad;

   logic [7:0] exp_q[$];

   uart_tx_fifo #(
      .CLK_FREQ   (1000000),
      .BAUD_RATE  (100000),
      .FIFO_DEPTH (4)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .i_wr_valid     (wr_valid),
      .i_wr_data      (wr_data),
      .o_wr_ready     (wr_ready),
      .o_fifo_count   (fifo_count),
      .o_busy         (busy),
      .o_overflow     (overflow),
      .i_clr_overflow (clr_overflow),
      .uart_tx        (uart_tx)
   );

   // Clock and reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Driver: one-cycle write strobe, called on a falling edge
   task automatic write_byte(input logic [7:0] d);
      wr_valid = 1'b1;
      wr_data  = d;
      tick();
      wr_valid = 1'b0;
   endtask

   // Frame checker: called 'already' clocks after the start bit began (<= 7),
   // samples each bit at clock 7 of its 10, returns on the first clock after the stop bit
   task automatic check_frame(input int already);
      logic [7:0] b;
      b = exp_q.pop_front();
      check("start_edge", {31'b0, uart_tx}, 0);
      repeat (7 - already) tick();
      check("start_bit", {31'b0, uart_tx}, 0);
      for (int i = 0; i < 8; i++) begin
         repeat (10) tick();
         check($sformatf("data%0d_of_%02h", i, b), {31'b0, uart_tx}, {31'b0, b[i]});
      end
      repeat (10) tick();
      check("stop_bit", {31'b0, uart_tx}, 1);
      repeat (2) tick();
      check("stop_last", {31'b0, uart_tx}, 1);
      check("busy_in_stop", {31'b0, busy}, 1);
      tick();
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_tx"}, {31'b0, uart_tx}, 1);
      check({tag, "_busy"}, {31'b0, busy}, 0);
      check({tag, "_count"}, {29'b0, fifo_count}, 0);
   endtask

   task automatic count_lows(input int cycles, output int lows);
      lows = 0;
      for (int i = 0; i < cycles; i++) begin
         tick();
         if (uart_tx == 1'b0) lows++;
      end
   endtask

   initial begin
      int lows;
      total        = 0;
      bad          = 0;
      reset        = 1'b1;
      wr_valid     = 1'b0;
      wr_data      = 8'h00;
      clr_overflow = 1'b0;
      repeat (3) tick();
      reset = 1'b0;
      tick();

      // Reset state
      check("rst_count", {29'b0, fifo_count}, 0);
      check("rst_ready", {31'b0, wr_ready}, 1);
      check("rst_busy", {31'b0, busy}, 0);
      check("rst_ovf", {31'b0, overflow}, 0);
      check("rst_tx", {31'b0, uart_tx}, 1);

      // Single byte 0xA5, latency and full frame
      exp_q.push_back(8'hA5);
      write_byte(8'hA5);
      check("t1_count_n1", {29'b0, fifo_count}, 1);
      check("t1_tx_n1", {31'b0, uart_tx}, 1);
      check("t1_busy_n1", {31'b0, busy}, 1);
      tick();
      check("t1_count_n2", {29'b0, fifo_count}, 0);
      check_frame(0);
      check_idle("t1_end");

      // Three back-to-back bytes, contiguous frames
      exp_q.push_back(8'h01);
      exp_q.push_back(8'h02);
      exp_q.push_back(8'h03);
      wr_valid = 1'b1;
      wr_data  = 8'h01;
      tick();
      wr_data = 8'h02;
      tick();
      wr_data = 8'h03;
      tick();
      wr_valid = 1'b0;
      check("t2_count_peak", {29'b0, fifo_count}, 2);
      check_frame(1);
      check("t2_count_after1", {29'b0, fifo_count}, 1);
      check_frame(0);
      check("t2_count_after2", {29'b0, fifo_count}, 0);
      check_frame(0);
      check_idle("t2_end");

      // Overfill during a frame: 4 accepted, 5th dropped, then clear
      exp_q.push_back(8'h11);
      write_byte(8'h11);
      tick();
      for (int i = 0; i < 5; i++) begin
         wr_valid = 1'b1;
         wr_data  = 8'h21 + 8'(i);
         if (i < 4) exp_q.push_back(8'h21 + 8'(i));
         tick();
      end
      wr_valid = 1'b0;
      check("t3_ready", {31'b0, wr_ready}, 0);
      check("t3_ovf", {31'b0, overflow}, 1);
      check("t3_count", {29'b0, fifo_count}, 4);
      clr_overflow = 1'b1;
      tick();
      clr_overflow = 1'b0;
      check("t3_ovf_clr", {31'b0, overflow}, 0);
      check_frame(6);
      for (int i = 0; i < 4; i++) check_frame(0);
      check_idle("t3_end");
      count_lows(40, lows);
      check("t3_no_extra_frame", lows, 0);

      // Full FIFO, write on the same edge as the stop-bit pop
      write_byte(8'h31);
      tick();
      for (int i = 0; i < 4; i++) begin
         wr_valid = 1'b1;
         wr_data  = 8'h41 + 8'(i);
         exp_q.push_back(8'h41 + 8'(i));
         tick();
      end
      wr_valid = 1'b0;
      check("t4_full_count", {29'b0, fifo_count}, 4);
      check("t4_full_ready", {31'b0, wr_ready}, 0);
      repeat (95) tick();
      check("t4_stop_tx", {31'b0, uart_tx}, 1);
      wr_valid = 1'b1;
      wr_data  = 8'h55;
      tick();
      wr_valid = 1'b0;
      check("t4_count", {29'b0, fifo_count}, 3);
      check("t4_ovf", {31'b0, overflow}, 1);
      check("t4_ready", {31'b0, wr_ready}, 1);
      for (int i = 0; i < 4; i++) check_frame(0);
      check_idle("t4_end");
      clr_overflow = 1'b1;
      tick();
      clr_overflow = 1'b0;
      check("t4_ovf_clr", {31'b0, overflow}, 0);

      // Clear and dropped write together: set wins
      write_byte(8'h61);
      tick();
      for (int i = 0; i < 4; i++) begin
         wr_valid = 1'b1;
         wr_data  = 8'h71 + 8'(i);
         tick();
      end
      wr_valid     = 1'b1;
      wr_data      = 8'h75;
      clr_overflow = 1'b1;
      tick();
      wr_valid     = 1'b0;
      clr_overflow = 1'b0;
      check("t6_ovf_set_wins", {31'b0, overflow}, 1);
      check("t6_count", {29'b0, fifo_count}, 4);

      // Reset in the middle of data bit 3 of 0x61 (bit value 0)
      repeat (39) tick();
      check("t5_bit3_before_rst", {31'b0, uart_tx}, 0);
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("t5_tx", {31'b0, uart_tx}, 1);
      check("t5_count", {29'b0, fifo_count}, 0);
      check("t5_busy", {31'b0, busy}, 0);
      check("t5_ready", {31'b0, wr_ready}, 1);
      check("t5_ovf", {31'b0, overflow}, 0);
      count_lows(200, lows);
      check("t5_no_frames", lows, 0);
      check_idle("t5_end");

      // Final report
      check("sb_drain", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
